pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the processor fetch stage. It replaces the fixed 16-bit PC unit and adds four things: configurable PC and offset widths, call/return support through an internal return-address stack (RAS), RAS error reporting, and an optional exception-PC capture. It sits between instruction decode (which supplies the control strobes and the offset) and instruction fetch (which consumes `PC`).

---
 rtl/pc_pkg.sv | 34 +++
 rtl/ras_stack.sv | 73 +++++++
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: the default trap
// vector and the decoded per-edge operation.
package pc_pkg;

    // Trap vector before truncation to the PC width (all-ones PC masked with 'hfff0).
    localparam logic [63:0] PC_TRAP_MASK = 64'hfff0;

    // One operation is selected per clock edge.
    typedef enum logic [2:0] {
        PC_HOLD,
        PC_SEQ,
        PC_JMP,
        PC_CALL,
        PC_RET,
        PC_TRAP
    } pc_op_e;

    // Priority: overflow > hold > ret > call > jump > sequential.
    function automatic pc_op_e pc_decode(
        input logic overflow,
        input logic update,
        input logic ret,
        input logic call,
        input logic jump
    );
        if (overflow)     return PC_TRAP;
        else if (!update) return PC_HOLD;
        else if (ret)     return PC_RET;
        else if (call)    return PC_CALL;
        else if (jump)    return PC_JMP;
        else              return PC_SEQ;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry. A pop when empty leaves the stack unchanged. Either case raises a
// registered one-cycle error pulse. Entry storage has no reset.
module ras_stack
    import pc_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] push_data_i,
    output logic [PC_W-1:0] top_o,
    output logic            empty_o,
    output logic            full_o,
    output logic            err_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // The write pointer addresses the next free slot, so the top is one below it.
    assign top_o   = mem_q[wp_q - PTR_W'(1)];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign err_o   = err_q;

    // Pointer, count and error next state. A push takes precedence over a pop.
    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        err_d   = 1'b0;
        if (push_i) begin
            wp_d = wp_q + PTR_W'(1);
            if (full_o) err_d = 1'b1;
            else        count_d = count_q + CNT_W'(1);
        end else if (pop_i) begin
            if (empty_o) begin
                err_d = 1'b1;
            end else begin
                wp_d    = wp_q - PTR_W'(1);
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry storage is written on every push. It has no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wp_q] <= push_data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer with a return-address stack.
// Optional feature macro: PC_EPC_EN. When it is defined, a trap captures the
// pre-trap PC in epc. When it is undefined, epc is tied to zero.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              OFF_W     = 12,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(PC_TRAP_MASK)
) (
    input  logic             Clk2,
    input  logic             reset,
    input  logic             updatePC,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [OFF_W-1:0] offset,
    input  logic             overflow,
    output logic [PC_W-1:0]  PC,
    output logic             rasEmpty,
    output logic             rasFull,
    output logic             rasErr,
    output logic [PC_W-1:0]  epc
);

    pc_op_e          op;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc, pc_tgt, off_sext;
    logic [PC_W-1:0] ras_top;
    logic            ras_push, ras_pop;

    // Decode the strobes into a single prioritised operation.
    always_comb begin
        op = pc_decode(overflow, updatePC, ret, call, jump);
    end

    // The signed cast sign-extends even when OFF_W equals PC_W. All sums wrap modulo 2^PC_W.
    assign off_sext = PC_W'($signed(offset));
    assign pc_inc   = pc_q + PC_W'(1);
    assign pc_tgt   = pc_q + off_sext;

    assign ras_push = (op == PC_CALL);
    assign ras_pop  = (op == PC_RET);

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (Clk2),
        .rst_ni      (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_inc),
        .top_o       (ras_top),
        .empty_o     (rasEmpty),
        .full_o      (rasFull),
        .err_o       (rasErr)
    );

    // Next PC. A return with an empty stack falls through to PC+1.
    always_comb begin
        pc_d = pc_inc;
        unique case (op)
            PC_TRAP: pc_d = TRAP_VEC;
            PC_HOLD: pc_d = pc_q;
            PC_RET:  pc_d = rasEmpty ? pc_inc : ras_top;
            PC_CALL: pc_d = pc_tgt;
            PC_JMP:  pc_d = pc_tgt;
            default: pc_d = pc_inc;
        endcase
    end

    // PC register.
    always_ff @(posedge Clk2 or negedge reset) begin
        if (!reset) pc_q <= '0;
        else        pc_q <= pc_d;
    end

    assign PC = pc_q;

`ifdef PC_EPC_EN
    logic [PC_W-1:0] epc_q;

    // Capture the PC of the trapping instruction and hold it until the next trap.
    always_ff @(posedge Clk2 or negedge reset) begin
        if (!reset)              epc_q <= '0;
        else if (op == PC_TRAP)  epc_q <= pc_q;
    end

    assign epc = epc_q;
`else
    assign epc = '0;
`endif

    // A trap always lands on the vector, and the stack never sees a push and a pop together.
    a_trap_vec: assert property (@(posedge Clk2) disable iff (!reset)
        (op == PC_TRAP) |=> (PC == TRAP_VEC));
    a_push_pop_excl: assert property (@(posedge Clk2) disable iff (!reset)
        !(ras_push && ras_pop));

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. The reference model keeps the
// return-address stack as a bounded queue and computes each PC step with
// modular arithmetic. Directed test-plan steps are followed by random stimulus.
module tb_pc_sequencer;

    localparam int PC_W  = 16;
    localparam int OFF_W = 12;
    localparam int DEPTH = 4;
    localparam logic [PC_W-1:0] TRAP = 16'hfff0;

    logic             Clk2     = 1'b0;
    logic             reset    = 1'b0;
    logic             updatePC = 1'b0;
    logic             jump     = 1'b0;
    logic             call     = 1'b0;
    logic             ret      = 1'b0;
    logic             overflow = 1'b0;
    logic [OFF_W-1:0] offset   = '0;
    logic [PC_W-1:0]  PC;
    logic             rasEmpty;
    logic             rasFull;
    logic             rasErr;
    logic [PC_W-1:0]  epc;

    pc_sequencer #(
        .PC_W      (PC_W),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .Clk2     (Clk2),
        .reset    (reset),
        .updatePC (updatePC),
        .jump     (jump),
        .call     (call),
        .ret      (ret),
        .offset   (offset),
        .overflow (overflow),
        .PC       (PC),
        .rasEmpty (rasEmpty),
        .rasFull  (rasFull),
        .rasErr   (rasErr),
        .epc      (epc)
    );

    // Clock and counters.
    always #5 Clk2 = ~Clk2;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state. exp_q holds the expected return addresses, oldest first.
    logic [PC_W-1:0] m_pc  = '0;
    logic [PC_W-1:0] m_epc = '0;
    logic            m_err = 1'b0;
    logic [PC_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pc"},    32'(PC),       32'(m_pc));
        check({tag, "_empty"}, 32'(rasEmpty), 32'(exp_q.size() == 0));
        check({tag, "_full"},  32'(rasFull),  32'(exp_q.size() == DEPTH));
        check({tag, "_err"},   32'(rasErr),   32'(m_err));
        check({tag, "_epc"},   32'(epc),      32'(m_epc));
    endtask

    function automatic logic [PC_W-1:0] sext(input logic [OFF_W-1:0] o);
        int s;
        s = int'(o);
        if (o[OFF_W-1]) s = s - (1 << OFF_W);
        return PC_W'(s);
    endfunction

    task automatic model_reset();
        m_pc  = '0;
        m_epc = '0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    // Behavioural model of one rising edge.
    task automatic model_edge(input logic upd, input logic jmp, input logic cl,
                              input logic rt, input logic ovf, input logic [OFF_W-1:0] off);
        m_err = 1'b0;
        if (ovf) begin
`ifdef PC_EPC_EN
            m_epc = m_pc;
`endif
            m_pc = TRAP;
        end else if (!upd) begin
            m_pc = m_pc;
        end else if (rt) begin
            if (exp_q.size() > 0) begin
                m_pc = exp_q.pop_back();
            end else begin
                m_pc  = m_pc + 16'd1;
                m_err = 1'b1;
            end
        end else if (cl) begin
            if (exp_q.size() == DEPTH) begin
                void'(exp_q.pop_front());
                m_err = 1'b1;
            end
            exp_q.push_back(m_pc + 16'd1);
            m_pc = m_pc + sext(off);
        end else if (jmp) begin
            m_pc = m_pc + sext(off);
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    // Drive the inputs, take one edge, then compare all outputs 1 ns later.
    task automatic cyc(input logic upd, input logic jmp, input logic cl, input logic rt,
                       input logic ovf, input logic [OFF_W-1:0] off, input string tag);
        updatePC = upd;
        jump     = jmp;
        call     = cl;
        ret      = rt;
        overflow = ovf;
        offset   = off;
        @(posedge Clk2);
        model_edge(upd, jmp, cl, rt, ovf, off);
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges. It must take effect before the next edge.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge Clk2);
        reset = 1'b1;
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge Clk2);
        model_reset();
        check_all("reset");
        reset = 1'b1;

        // Three sequential edges.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 12'h000, "seq");
        check("tp_seq3", 32'(PC), 32'h3);

        // Call then return.
        cyc(1, 1, 0, 0, 0, 12'h00d, "jmp_to_10");
        cyc(1, 0, 1, 0, 0, 12'h020, "call");
        check("tp_call_pc", 32'(PC), 32'h30);
        cyc(1, 0, 0, 1, 0, 12'h000, "ret");
        check("tp_ret_pc", 32'(PC), 32'h11);

        // Five nested calls overflow the stack. Five returns then drain it and underflow.
        for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0, 12'h010, "ncall");
        check("tp_call5_err", 32'(rasErr), 32'h1);
        check("tp_call5_full", 32'(rasFull), 32'h1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0, 12'h000, "nret");
        check("tp_ret5_err", 32'(rasErr), 32'h1);

        // Negative jump to all-ones, then a sequential wrap to zero.
        cyc(0, 0, 0, 0, 1, 12'h000, "trap0");
        cyc(1, 1, 0, 0, 0, 12'h015, "jmp_to_5");
        check("tp_pc5", 32'(PC), 32'h5);
        cyc(1, 1, 0, 0, 0, 12'hffa, "jmp_neg");
        check("tp_pc_ffff", 32'(PC), 32'hffff);
        cyc(1, 0, 0, 0, 0, 12'h000, "wrap");
        check("tp_wrap", 32'(PC), 32'h0);

        // Reach 0x1234 with one entry on the stack, then trap with hold and call also asserted.
        cyc(1, 0, 1, 0, 0, 12'h7ff, "call_far");
        cyc(1, 1, 0, 0, 0, 12'h7ff, "jmp_far");
        cyc(1, 1, 0, 0, 0, 12'h236, "jmp_1234");
        check("tp_pc1234", 32'(PC), 32'h1234);
        cyc(0, 0, 1, 0, 1, 12'h055, "trap");
        check("tp_trap_pc", 32'(PC), 32'hfff0);
        check("tp_trap_ras", 32'(rasEmpty), 32'h0);
`ifdef PC_EPC_EN
        check("tp_trap_epc", 32'(epc), 32'h1234);
`else
        check("tp_trap_epc", 32'(epc), 32'h0);
`endif
        // A hold keeps everything unchanged.
        cyc(0, 1, 1, 1, 0, 12'h123, "hold");

        // Asynchronous reset in the middle of a call sequence.
        cyc(1, 0, 1, 0, 0, 12'h040, "pre_rst_call");
        mid_reset("async_rst");
        check("tp_rst_pc", 32'(PC), 32'h0);
        cyc(1, 0, 0, 0, 0, 12'h000, "post_rst_seq");
        check("tp_post_rst", 32'(PC), 32'h1);

        // Random stimulus against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset("rnd_rst");
            end else begin
                cyc(1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 31) == 0),
                    12'($urandom),
                    "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
